// File: rtl/sum_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Holds the nibble width and the controller FSM state encoding.
package sum_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int nibbles);
    return $clog2(nibbles) + 1;
  endfunction

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit adder with carry in/out.
// Ports: x, y (addends), ci (carry in), s (sum), co (carry out).
module nibble_add4
  import sum_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [NIBBLE_W:0] t;

  assign t  = {1'b0, x} + {1'b0, y} + {{NIBBLE_W{1'b0}}, ci};
  assign s  = t[NIBBLE_W-1:0];
  assign co = t[NIBBLE_W];

endmodule

// File: rtl/sum_serial_ctrl.sv
// Nibble-serial adder: one 4-bit adder summing W-bit operands LSB first.
// Ports: clk, rst_n, in_valid/in_ready/a/b, out_valid/out_ready/sum/cout, busy.
module sum_serial_ctrl
  import sum_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                        cout,
  output logic                        busy
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int CW = cnt_width(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t               state;
  logic [W-1:0]         a_sh;
  logic [W-1:0]         b_sh;
  logic [W-1:0]         res;
  logic                 carry;
  logic [CW-1:0]        cnt;
  logic [NIBBLE_W-1:0]  nib;
  logic                 nco;
  logic [W-1:0]         res_nx;

  nibble_add4 u_add (
    .x  (a_sh[NIBBLE_W-1:0]),
    .y  (b_sh[NIBBLE_W-1:0]),
    .ci (carry),
    .s  (nib),
    .co (nco)
  );

  // New nibble enters at the top; after NIBBLES steps
  // the LSB nibble has reached bit 0.
  assign res_nx = (res >> NIBBLE_W)
                | (W'(nib) << (W - NIBBLE_W));

  assign sum = res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      res       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      cout      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_sh     <= a;
            b_sh     <= b;
            carry    <= 1'b0;
            cnt      <= '0;
            cout     <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> NIBBLE_W;
          b_sh  <= b_sh >> NIBBLE_W;
          res   <= res_nx;
          carry <= nco;
          if (cnt == LAST) begin
            cout      <= nco;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_serial_ctrl.sv
// Directed bench for sum_serial_ctrl (16-bit and 4-bit instances).
// Expected results are hand-computed constants or a+b in the bench.
module tb_sum_serial_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a_i = '0;
  logic [15:0] b_i = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        busy;

  logic        in_valid1 = 1'b0;
  logic        in_ready1;
  logic [3:0]  a1 = '0;
  logic [3:0]  b1 = '0;
  logic        out_valid1;
  logic        out_ready1 = 1'b1;
  logic [3:0]  sum1;
  logic        cout1;
  logic        busy1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sum_serial_ctrl #(.NIBBLES(4)) u0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a_i), .b(b_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  sum_serial_ctrl #(.NIBBLES(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1)
  );

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, busy, cout} !== 4'b0000 || sum !== 16'h0) begin
        failures++;
        $display("FAIL reset_hold got rdy=%b vld=%b busy=%b cout=%b sum=%h exp all 0",
                 in_ready, out_valid, busy, cout, sum);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, cout} !== 4'b1000 || sum !== 16'h0) begin
      failures++;
      $display("FAIL reset_release got rdy=%b vld=%b busy=%b cout=%b sum=%h exp rdy=1 rest 0",
               in_ready, out_valid, busy, cout, sum);
    end
  endtask

  // One 16-bit operation; hold>0 keeps out_ready low that many cycles in DONE.
  task automatic op16(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] es, input logic ec,
                      input int hold, input string nm);
    int n;
    logic [15:0] s0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready got=%b exp=1", nm, in_ready);
    end
    a_i = a;
    b_i = b;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    // junk operands while running must be ignored
    a_i = 16'hDEAD;
    b_i = 16'hBEEF;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_run got busy=%b rdy=%b exp busy=1 rdy=0", nm, busy, in_ready);
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL %s_latency got=%0d exp=4", nm, n);
    end
    checks++;
    if (sum !== es || cout !== ec) begin
      failures++;
      $display("FAIL %s_sum got=%b_%h exp=%b_%h", nm, cout, sum, ec, es);
    end
    s0 = sum;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (sum !== s0 || cout !== ec || out_valid !== 1'b1 ||
          busy !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s_hold%0d got sum=%h cout=%b vld=%b busy=%b rdy=%b exp sum=%h cout=%b 1 1 0",
                 nm, k, sum, cout, out_valid, busy, in_ready, s0, ec);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_after got vld=%b rdy=%b busy=%b exp 0 1 0",
               nm, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_basic;
    op16(16'h1234, 16'h4321, 16'h5555, 1'b0, 0, "basic");
  endtask

  task automatic test_ripple;
    op16(16'hFFFF, 16'h0001, 16'h0000, 1'b1, 0, "ripple");
    op16(16'h8000, 16'h8000, 16'h0000, 1'b1, 0, "msb_ovf");
  endtask

  task automatic test_backpressure;
    op16(16'h00FF, 16'h0001, 16'h0100, 1'b0, 5, "bp");
  endtask

  task automatic test_abort;
    @(negedge clk);
    a_i = 16'hFFFF;
    b_i = 16'hFFFF;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, cout} !== 4'b0000 || sum !== 16'h0) begin
      failures++;
      $display("FAIL abort_reset got rdy=%b vld=%b busy=%b cout=%b sum=%h exp all 0",
               in_ready, out_valid, busy, cout, sum);
    end
    #1;
    rst_n = 1'b1;
    op16(16'h000F, 16'h0001, 16'h0010, 1'b0, 0, "post_abort");
  endtask

  task automatic test_back_to_back;
    int n;
    int bad_sum = 0;
    int bad_lat = 0;
    logic [4:0] exp5;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready1 !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready i=%0d got=%b exp=1", i, in_ready1);
      end
      a1 = i[3:0];
      b1 = i[7:4];
      in_valid1 = 1'b1;
      @(negedge clk);
      in_valid1 = 1'b0;
      n = 0;
      while (out_valid1 !== 1'b1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      exp5 = {1'b0, a1} + {1'b0, b1};
      checks++;
      if (n !== 1) begin
        failures++;
        bad_lat++;
        if (bad_lat < 5)
          $display("FAIL b2b_latency i=%0d got=%0d exp=1", i, n);
      end
      checks++;
      if ({cout1, sum1} !== exp5) begin
        failures++;
        bad_sum++;
        if (bad_sum < 5)
          $display("FAIL b2b_sum a=%h b=%h got=%h exp=%h", a1, b1, {cout1, sum1}, exp5);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ripple();
    test_backpressure();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
